// File: rtl/seq_det_pkg.sv
// Shared types and limits for the parametrised serial-pattern detector.
package seq_det_pkg;

  typedef enum logic [1:0] {IDLE, SEARCH, MATCH} seq_state_t;

  localparam int PAT_LEN_MAX = 32;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and synchronous active-low reset.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  // Clear beats increment; the count holds once it reaches all-ones.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// Moore serial-pattern detector with loadable pattern, overlap mode and saturating match count.
// Optional don't-care mask on the compare is enabled by defining SEQ_DET_MASK_EN.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int PAT_LEN = 4,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               en,
  input  logic               pat_load,
  input  logic [PAT_LEN-1:0] pattern_in,
`ifdef SEQ_DET_MASK_EN
  input  logic [PAT_LEN-1:0] mask_in,
`endif
  input  logic               overlap,
  input  logic               i_valid,
  input  logic               i,
  input  logic               clr_count,
  output logic               match,
  output logic [CNT_W-1:0]   match_count,
  output logic               busy
);

  localparam int FILL_W = $clog2(PAT_LEN + 1);

  if (PAT_LEN < 2 || PAT_LEN > PAT_LEN_MAX) begin : g_bad_pat_len
    $error("seq_detector_param: PAT_LEN out of range");
  end

  seq_state_t          state_q, state_d;
  logic [PAT_LEN-1:0]  hist_q, hist_d, hist_shift;
  logic [PAT_LEN-1:0]  pat_q;
  logic [PAT_LEN-1:0]  mask_q;
  logic [FILL_W-1:0]   fill_q, fill_d, fill_inc;
  logic                take;
  logic                hit;

`ifdef SEQ_DET_MASK_EN
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      mask_q <= '0;
    end else if (pat_load) begin
      mask_q <= mask_in;
    end
  end
`else
  assign mask_q = '0;
`endif

  // A bit is only consumed while actively searching and not being overridden by en/pat_load.
  always_comb begin
    hist_shift = {hist_q[PAT_LEN-2:0], i};
    fill_inc   = (fill_q == FILL_W'(PAT_LEN)) ? fill_q : fill_q + FILL_W'(1);
    take       = en && !pat_load && (state_q != IDLE) && i_valid;
    hit        = take && (fill_q >= FILL_W'(PAT_LEN - 1)) &&
                 (((hist_shift ^ pat_q) & ~mask_q) == '0);
  end

  always_comb begin
    state_d = state_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    if (!en) begin
      state_d = IDLE;
      hist_d  = '0;
      fill_d  = '0;
    end else if (pat_load) begin
      state_d = SEARCH;
      hist_d  = '0;
      fill_d  = '0;
    end else begin
      case (state_q)
        IDLE: state_d = SEARCH;
        SEARCH, MATCH: begin
          state_d = SEARCH;
          if (take) begin
            hist_d = hist_shift;
            fill_d = fill_inc;
            // Non-overlapping mode demands PAT_LEN fresh bits after every match.
            if (hit && (state_q == SEARCH || overlap)) begin
              state_d = MATCH;
              if (!overlap) fill_d = '0;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q <= IDLE;
      hist_q  <= '0;
      fill_q  <= '0;
      pat_q   <= '0;
    end else begin
      state_q <= state_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      if (pat_load) pat_q <= pattern_in;
    end
  end

  sat_counter #(.W(CNT_W)) u_match_cnt (
    .clk   (clk),
    .n_rst (n_rst),
    .inc   (state_d == MATCH),
    .clr   (clr_count),
    .count (match_count)
  );

  assign match = (state_q == MATCH);
  assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_seq_detector_param.sv
// Scoreboard bench for seq_detector_param: a wide-count and a 2-bit-count instance share stimulus.
module tb_seq_detector_param;

  localparam int PAT_LEN = 4;

  logic         clk = 1'b0;
  logic         n_rst, en, pat_load, overlap, i_valid, i, clr_count;
  logic [3:0]   pattern_in;
`ifdef SEQ_DET_MASK_EN
  logic [3:0]   mask_in;
`endif
  logic         match, busy, match2, busy2;
  logic [7:0]   cnt;
  logic [1:0]   cnt2;

  seq_detector_param #(.PAT_LEN(PAT_LEN), .CNT_W(8)) dut (
    .clk(clk), .n_rst(n_rst), .en(en), .pat_load(pat_load), .pattern_in(pattern_in),
`ifdef SEQ_DET_MASK_EN
    .mask_in(mask_in),
`endif
    .overlap(overlap), .i_valid(i_valid), .i(i), .clr_count(clr_count),
    .match(match), .match_count(cnt), .busy(busy)
  );

  seq_detector_param #(.PAT_LEN(PAT_LEN), .CNT_W(2)) dut_sat (
    .clk(clk), .n_rst(n_rst), .en(en), .pat_load(pat_load), .pattern_in(pattern_in),
`ifdef SEQ_DET_MASK_EN
    .mask_in(mask_in),
`endif
    .overlap(overlap), .i_valid(i_valid), .i(i), .clr_count(clr_count),
    .match(match2), .match_count(cnt2), .busy(busy2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic match;
    logic busy;
    int   cnt8;
    int   cnt2;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model state (0 = idle, 1 = search, 2 = match)
  int         m_state = 0;
  int         m_fill  = 0;
  logic [3:0] m_hist  = '0;
  logic [3:0] m_pat   = '0;
  logic [3:0] m_mask  = '0;
  int         m_cnt8  = 0;
  int         m_cnt2  = 0;

  task automatic step(input logic rst_b, input logic e, input logic pl,
                      input logic [3:0] pat, input logic [3:0] msk, input logic ov,
                      input logic v, input logic b, input logic clr, input string tag);
    exp_t       ex;
    exp_t       got;
    logic [3:0] nh;
    logic       hit;
    n_rst = rst_b; en = e; pat_load = pl; pattern_in = pat; overlap = ov;
    i_valid = v; i = b; clr_count = clr;
`ifdef SEQ_DET_MASK_EN
    mask_in = msk;
`endif
    if (!rst_b) begin
      m_state = 0; m_fill = 0; m_hist = '0; m_pat = '0; m_mask = '0;
      m_cnt8 = 0; m_cnt2 = 0;
    end else begin
      if (!e) begin
        m_state = 0; m_hist = '0; m_fill = 0;
      end else if (pl) begin
        m_state = 1; m_hist = '0; m_fill = 0;
      end else if (m_state == 0 || !v) begin
        m_state = 1;
      end else begin
        nh  = {m_hist[2:0], b};
        hit = (m_fill >= 3) && (((nh ^ m_pat) & ~m_mask) == 4'b0000);
        m_hist = nh;
        if (m_fill < 4) m_fill++;
        if (hit && (m_state == 1 || ov)) begin
          m_state = 2;
          if (!ov) m_fill = 0;
        end else begin
          m_state = 1;
        end
      end
      if (pl) begin
        m_pat = pat;
`ifdef SEQ_DET_MASK_EN
        m_mask = msk;
`endif
      end
      if (clr) begin
        m_cnt8 = 0; m_cnt2 = 0;
      end else if (m_state == 2) begin
        if (m_cnt8 < 255) m_cnt8++;
        if (m_cnt2 < 3) m_cnt2++;
      end
    end
    ex.match = (m_state == 2);
    ex.busy  = (m_state != 0);
    ex.cnt8  = m_cnt8;
    ex.cnt2  = m_cnt2;
    exp_q.push_back(ex);

    @(posedge clk);
    #1;
    got = exp_q.pop_front();
    check({tag, ".match"},  {31'd0, match},  {31'd0, got.match});
    check({tag, ".busy"},   {31'd0, busy},   {31'd0, got.busy});
    check({tag, ".count"},  {24'd0, cnt},    got.cnt8);
    check({tag, ".count2"}, {30'd0, cnt2},   got.cnt2);
    check({tag, ".match2"}, {31'd0, match2}, {31'd0, got.match});
  endtask

  logic cur_ov = 1'b1;

  task automatic load(input logic [3:0] pat, input logic [3:0] msk, input string tag);
    step(1'b1, 1'b1, 1'b1, pat, msk, cur_ov, 1'b1, 1'b1, 1'b1, tag);
  endtask

  task automatic send(input logic b, input string tag);
    step(1'b1, 1'b1, 1'b0, 4'h0, 4'h0, cur_ov, 1'b1, b, 1'b0, tag);
  endtask

  task automatic gap(input string tag);
    step(1'b1, 1'b1, 1'b0, 4'h0, 4'h0, cur_ov, 1'b0, 1'b0, 1'b0, tag);
  endtask

  task automatic send_bits(input logic [15:0] bits, input int n, input string tag);
    for (int k = n - 1; k >= 0; k--) send(bits[k], tag);
  endtask

  initial begin
    // Reset
    step(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, "reset");
    check("rst_match", {31'd0, match}, 0);
    check("rst_busy",  {31'd0, busy}, 0);

    // Overlapping 1101 on 1101101
    cur_ov = 1'b1;
    load(4'b1101, 4'h0, "ov_load");
    send_bits(16'b1101101, 7, "ov");
    check("ov_count", {24'd0, cnt}, 2);

    // Non-overlapping, same stream
    cur_ov = 1'b0;
    load(4'b1101, 4'h0, "nov_load");
    send_bits(16'b1101101, 7, "nov");
    check("nov_count", {24'd0, cnt}, 1);

    // 1111 with seven ones, overlapping
    cur_ov = 1'b1;
    load(4'b1111, 4'h0, "ones_load");
    send_bits(16'b1111111, 7, "ones");
    check("ones_count", {24'd0, cnt}, 4);

    // Valid gaps between bits
    load(4'b1101, 4'h0, "gap_load");
    send(1'b1, "gap_b1"); repeat (3) gap("gap_g1");
    send(1'b1, "gap_b2"); repeat (3) gap("gap_g2");
    send(1'b0, "gap_b3"); repeat (3) gap("gap_g3");
    send(1'b1, "gap_b4");
    check("gap_match", {31'd0, match}, 1);
    gap("gap_after");
    check("gap_count", {24'd0, cnt}, 1);

    // Pattern reload mid-stream; bit on the load edge is discarded
    load(4'b1101, 4'h0, "rl_load1");
    send_bits(16'b110, 3, "rl_pre");
    step(1'b1, 1'b1, 1'b1, 4'b0110, 4'h0, cur_ov, 1'b1, 1'b1, 1'b0, "rl_load2");
    send_bits(16'b1101, 4, "rl_old");
    check("rl_old_count", {24'd0, cnt}, 0);
    send_bits(16'b0110, 4, "rl_new");
    check("rl_new_match", {31'd0, match}, 1);

    // Saturation of the 2-bit counter, then clear with a hit on the same edge
    load(4'b1111, 4'h0, "sat_load");
    send_bits(16'b111111111, 9, "sat");
    check("sat_count2", {30'd0, cnt2}, 3);
    check("sat_count8", {24'd0, cnt}, 6);
    step(1'b1, 1'b1, 1'b0, 4'h0, 4'h0, cur_ov, 1'b1, 1'b1, 1'b1, "sat_clr");
    check("clr_count2", {30'd0, cnt2}, 0);
    check("clr_match", {31'd0, match}, 1);

    // en low for one cycle mid-search
    load(4'b1101, 4'h0, "en_load");
    send_bits(16'b110, 3, "en_pre");
    step(1'b1, 1'b0, 1'b0, 4'h0, 4'h0, cur_ov, 1'b1, 1'b1, 1'b0, "en_off");
    check("en_off_busy", {31'd0, busy}, 0);
    step(1'b1, 1'b1, 1'b0, 4'h0, 4'h0, cur_ov, 1'b1, 1'b1, 1'b0, "en_on");
    send(1'b1, "en_post");
    check("en_nomatch", {31'd0, match}, 0);

    // Reset mid-search clears everything including the pattern
    send_bits(16'b110, 3, "rst2_pre");
    step(1'b0, 1'b1, 1'b0, 4'h0, 4'h0, cur_ov, 1'b1, 1'b1, 1'b0, "rst2");
    check("rst2_count", {24'd0, cnt}, 0);
    check("rst2_busy", {31'd0, busy}, 0);
    step(1'b1, 1'b1, 1'b0, 4'h0, 4'h0, cur_ov, 1'b0, 1'b0, 1'b0, "rst2_idle");
    send_bits(16'b0000, 4, "rst2_zero");

`ifdef SEQ_DET_MASK_EN
    // Masked compare: 1101 with bit1 don't-care accepts 1111
    load(4'b1101, 4'b0010, "mask_load");
    send_bits(16'b1111, 4, "mask");
    check("mask_match", {31'd0, match}, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
